// File: rtl/cpu_ctrl_seq.sv
// Fetch/decode/execute sequencer feeding an external 8-bit ALU; owns pc/acc/ir/mdr/zf.
// Optional memory-wait timeout enabled by defining CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module cpu_ctrl_seq #(
  parameter logic [7:0] RESET_PC       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_mem_addr,
  output logic       o_mem_rd,
  input  logic [7:0] i_mem_rdata,
  input  logic       i_mem_ready,
  input  logic [7:0] i_alu_x,
  output logic [1:0] o_sel_A,
  output logic [2:0] o_sel_B,
  output logic       o_CI,
  output logic [7:0] o_mdr,
  output logic [7:0] o_acc,
  output logic [7:0] o_pc,
  output logic       o_zf,
  output logic       o_halted,
  output logic       o_err
);
  typedef enum logic [2:0] {S_FETCH, S_INC1, S_OPRD, S_EXEC, S_INC2, S_HALT} state_t;

  localparam logic [2:0] OP_NOP = 3'b000, OP_LDI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011,
                         OP_JMP = 3'b100, OP_JZ  = 3'b101, OP_RSV = 3'b110, OP_HLT = 3'b111;

  state_t     r_state, w_next;
  logic [7:0] r_pc, r_acc, r_ir, r_mdr;
  logic       r_zf, r_err;
  logic       w_rd, w_take, w_timeout, w_pc_we, w_acc_we;
  logic [2:0] w_op;

  // Gating with i_rst drops the request on the reset edge so a late ready is never taken.
  assign w_rd   = ((r_state == S_FETCH) || (r_state == S_OPRD)) && !i_rst;
  assign w_take = w_rd && i_mem_ready;
  assign w_op   = r_ir[7:5];

`ifdef CTRL_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] r_wait;
  assign w_timeout = w_rd && !i_mem_ready && (r_wait == WW'(TIMEOUT_CYCLES - 1));

  // Counter is zero on every entry to a read state since it clears outside waits.
  always_ff @(posedge i_clk) begin
    if (i_rst)                    r_wait <= '0;
    else if (w_rd && !i_mem_ready) r_wait <= r_wait + 1'b1;
    else                          r_wait <= '0;
  end
  assign o_err = r_err;
`else
  assign w_timeout = 1'b0;
  assign o_err     = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    o_sel_A  = 2'b10;
    o_sel_B  = 3'b100;
    o_CI     = 1'b0;
    w_pc_we  = 1'b0;
    w_acc_we = 1'b0;
    case (r_state)
      S_FETCH, S_OPRD: begin
        if (w_take)         w_next = (r_state == S_FETCH) ? S_INC1 : S_EXEC;
        else if (w_timeout) w_next = S_HALT;
      end
      S_INC1: begin
        o_CI    = 1'b1;
        w_pc_we = 1'b1;
        case (w_op)
          OP_NOP, OP_RSV: w_next = S_FETCH;
          OP_HLT:         w_next = S_HALT;
          default:        w_next = S_OPRD;
        endcase
      end
      S_EXEC: begin
        w_next = S_INC2;
        case (w_op)
          OP_LDI: begin o_sel_A = 2'b00; w_acc_we = 1'b1; end
          OP_ADD: begin o_sel_A = 2'b01; o_sel_B = 3'b000; w_acc_we = 1'b1; end
          OP_SUB: begin o_sel_A = 2'b01; o_sel_B = 3'b001; o_CI = 1'b1; w_acc_we = 1'b1; end
          OP_JMP: begin o_sel_A = 2'b00; w_pc_we = 1'b1; w_next = S_FETCH; end
          OP_JZ: begin
            if (r_zf) begin o_sel_A = 2'b00; w_pc_we = 1'b1; w_next = S_FETCH; end
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_INC2: begin
        o_CI    = 1'b1;
        w_pc_we = 1'b1;
        w_next  = S_FETCH;
      end
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_acc   <= 8'h00;
      r_ir    <= 8'h00;
      r_mdr   <= 8'h00;
      r_zf    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_mdr <= i_mem_rdata;
        if (r_state == S_FETCH) r_ir <= i_mem_rdata;
      end
      if (w_pc_we) r_pc <= i_alu_x;
      if (w_acc_we) begin
        r_acc <= i_alu_x;
        r_zf  <= (i_alu_x == 8'h00);
      end
      if (w_timeout) r_err <= 1'b1;
    end
  end

  assign o_mem_addr = r_pc;
  assign o_mem_rd   = w_rd;
  assign o_mdr      = r_mdr;
  assign o_acc      = r_acc;
  assign o_pc       = r_pc;
  assign o_zf       = r_zf;
  assign o_halted   = (r_state == S_HALT);
endmodule
